// File: rtl/genie_sram_pkg.sv
// genie_sram_pkg: shared constants and types for the Genie ext_sram read/write arbiters.
//   SRAM_ADDR_W / SRAM_DATA_W : default ext_sram word address / data widths
//   sram_arb_state_t          : arbiter FSM states (ARB = round-robin, LOCK = burst owner)
//   id_width()                : width of a client index for n clients (never below 1)
package genie_sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 26;
  localparam int unsigned SRAM_DATA_W = 32;

  typedef enum logic {ARB, LOCK} sram_arb_state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rd_arbiter_rr_pick.sv
// rr_pick: N-way round-robin priority picker.
//   req    in  N      request vector
//   ptr    in  ID_W   highest-priority index this cycle (must be < N)
//   any    out 1      at least one request present
//   idx    out ID_W   index of the first request found from ptr upward, wrapping mod N
//   onehot out N      same selection as a one-hot vector (all zero when !any)
module rr_pick import genie_sram_pkg::*; #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx,
  output logic [N-1:0]    onehot
);

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned c;
      c = 32'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = ID_W'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_rd_arbiter.sv
// sram_rd_arbiter: shares the ext_sram R0 read port between N_REQ clients.
//   Round-robin grant with burst lock (capped at MAX_BURST beats), zero-cycle grant latency,
//   and a tag pipeline that steers the fixed-latency rdata back to the issuing client.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-client request handshake
//   req_addr            client i address at [i*ADDR_W +: ADDR_W]
//   req_last            1 = final beat of the client's burst
//   rvalid/rready/raddr ext_sram R0 request channel
//   rdata               ext_sram R0 data, valid RD_LAT cycles after the handshake
//   rsp_valid           one-hot owner of rsp_data this cycle
//   rsp_data            rdata broadcast to all clients
// Optional (SRAM_ARB_STATS_EN defined):
//   stat_gnt_cnt        per-client saturating handshake counts, 16 bits each
//   stat_stall_cnt      saturating count of cycles with rvalid & !rready
module sram_rd_arbiter import genie_sram_pkg::*; #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_last,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ADDR_W-1:0]       raddr,
  input  logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     stat_gnt_cnt,
  output logic [15:0]             stat_stall_cnt
`endif
);

  localparam int unsigned ID_W  = id_width(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST);

  sram_arb_state_t   state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]   sel_id;
  logic              sel_valid;
  logic              hs;
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  logic [RD_LAT-1:0] tag_vld_q;
  logic [ID_W-1:0]   tag_id_q [RD_LAT];

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (32'(id) == N_REQ - 1) ? '0 : id + ID_W'(1);
  endfunction

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Request channel is purely combinational from req_*; rst masks it so a
  // handshake can never coincide with reset.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    burst_cnt_d = burst_cnt_q;
    req_ready   = '0;
    sel_id      = pick_idx;
    sel_valid   = pick_any;

    if (state_q == LOCK) begin
      sel_id    = lock_id_q;
      sel_valid = req_valid[lock_id_q];
    end

    rvalid = sel_valid & ~rst;
    raddr  = addr_arr[sel_id];
    if (rvalid) begin
      if (state_q == LOCK) req_ready[lock_id_q] = rready;
      else                 req_ready = pick_onehot & {N_REQ{rready}};
    end
    hs = rvalid & rready;

    unique case (state_q)
      ARB: begin
        if (hs) begin
          if (req_last[sel_id]) begin
            rr_ptr_d = next_id(sel_id);
          end else begin
            state_d     = LOCK;
            lock_id_d   = sel_id;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCK: begin
        if (hs) begin
          // Forced release on the MAX_BURST-th beat keeps other clients' wait bounded.
          if (req_last[sel_id] || burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d     = ARB;
            rr_ptr_d    = next_id(sel_id);
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Tag pipeline mirrors the SRAM read latency; reset drops reads in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= hs;
      tag_id_q[0]  <= sel_id;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (!rst && tag_vld_q[RD_LAT-1]) rsp_valid[tag_id_q[RD_LAT-1]] = 1'b1;
  end

  assign rsp_data = rdata;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] gnt_cnt_q [N_REQ];
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) gnt_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (hs && gnt_cnt_q[sel_id] != 16'hFFFF) gnt_cnt_q[sel_id] <= gnt_cnt_q[sel_id] + 16'd1;
      if (rvalid && !rready && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_gnt_cnt[g*16 +: 16] = gnt_cnt_q[g];
  end
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
